aqed_fc_multi_tracker: RTL and testbench
========================================

Name: aqed_fc_multi_tracker

Overview:
- Parametrised A-QED functional-consistency tracker for formal top-levels of streaming accelerators such as memory_core.
- Forwards the BMC-driven input stream to the DUT and, through free inputs, marks up to NUM_PAIRS original/duplicate transaction pairs.
- Captures the DUT output for each marked transaction and reports whether each pair's outputs match.
- Generalises the single-pair tracker: parametrised width, counter width and pair count, data-equality pairing, and per-slot status.

Parameters:
- DATA_W, 16: data width of the input and output streams.
- CNT_W, 8: width of the transaction sequence counters.
- NUM_PAIRS, 2: number of concurrently tracked orig/dup pairs (1..8).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_data  in  DATA_W  BMC input data
- in_valid  in  1  BMC input valid
- in_ready  out  1  input accepted this cycle when in_valid is also high
- mark_orig  in  1  free input: tag the current accepted input as an original
- mark_dup  in  1  free input: tag the current accepted input as a duplicate
- acc_in_data  out  DATA_W  data to the DUT
- acc_in_valid  out  1  valid to the DUT
- acc_in_ready  in  1  DUT ready
- acc_out_data  in  DATA_W  DUT result
- acc_out_valid  in  1  DUT result valid; no backpressure
- slot_done  out  NUM_PAIRS  per-slot, both outputs captured
- slot_match  out  NUM_PAIRS  per-slot, captured outputs equal (qualified by slot_done)
- qed_done  out  1  OR of slot_done
- qed_check  out  1  AND of slot_match over all done slots; 1 when none are done

Behaviour:
- Forwarding is combinational:
  - acc_in_data = in_data; acc_in_valid = in_valid; in_ready = acc_in_ready.
  - in_acc = in_valid & acc_in_ready.
- DUT contract: one output per accepted input, in order.
- Counters:
  - in_cnt increments on in_acc; out_cnt increments on acc_out_valid.
  - Both reset to 0 and saturate at 2^CNT_W-1.
  - When in_cnt is saturated, marks are ignored; forwarding continues.
- Slot FSM, per slot: IDLE -> ORIG -> PAIRED -> DONE.
  - IDLE->ORIG: on in_acc & mark_orig, the lowest-index IDLE slot latches orig_data=in_data and orig_idx=in_cnt. If no slot is IDLE, the mark is ignored.
  - ORIG->PAIRED: on in_acc & mark_dup & ~mark_orig, the lowest-index ORIG slot whose orig_data==in_data latches dup_idx=in_cnt. If no slot matches, the mark is ignored. When mark_orig and mark_dup are both high, orig wins.
  - Output capture: in ORIG or PAIRED, on acc_out_valid with out_cnt==orig_idx, latch orig_res and set orig_got. In PAIRED, on acc_out_valid with out_cnt==dup_idx, latch dup_res and set dup_got.
  - PAIRED->DONE: the cycle after both orig_got and dup_got are set.
  - DONE is sticky until reset.
- Same-cycle events:
  - Input accepted and output produced in the same cycle: both counters update; capture compares against the pre-increment out_cnt.
  - A transaction accepted and output in the same cycle can be marked and captured in that cycle, using the pre-increment in_cnt and out_cnt.
- Outputs:
  - slot_done[k] = (state_k==DONE).
  - slot_match[k] = slot_done[k] & (orig_res_k==dup_res_k).
  - qed_done and qed_check are combinational from slot state.
- Reset values (asserting reset low at any time, including mid-operation): all slots IDLE, counters 0, *_got flags 0, slot_done=0, slot_match=0, qed_done=0, qed_check=1.
- Latency: the last capture edge plus one cycle gives slot_done.
- Formal contract: qed_done |-> qed_check.

Decomposition:
- aqed_pkg holds:
  - slot_state_e {IDLE, ORIG, PAIRED, DONE}
  - the NUM_PAIRS bound
  - a helper function for lowest-set-bit priority select
- One sub-module, aqed_pair_slot, per pair: holds FSM, data/index registers and capture logic.
- The top owns the counters, allocation/pairing priority encoders and the output reductions.

Test Plan:
- Single pair: accept 0x0005 with mark_orig (idx0), 0x0007, then 0x0005 with mark_dup (idx2); DUT returns 0x00A0,0x00B0,0x00A0 -> slot_done[0]=1 one cycle after the third output; qed_check=1.
- Mismatch: same stimulus, third output 0x00A1 -> qed_done=1, qed_check=0, slot_match[0]=0.
- Two pairs interleaved: orig 0x0011, orig 0x0022, dup 0x0022, dup 0x0011 -> slot1 pairs with the third input and slot0 with the fourth; both slot_done set; qed_check=1.
- Unmatched dup: orig 0x0003, dup-marked 0x0004 -> dup ignored, slot0 stays ORIG, qed_done=0; a later dup 0x0003 pairs normally.
- Backpressure and simultaneity: acc_in_ready=0 while in_valid=1 with mark_orig -> no allocation and in_cnt unchanged; mark_orig and mark_dup together -> orig allocation only; input accept and output in the same cycle -> correct indices.
- Reset mid-operation: drive reset low while slot0 is PAIRED -> all outputs at reset values asynchronously; post-reset in_cnt restarts at 0.

Source files
------------

// File: rtl/aqed_pkg.sv
// Shared types and helpers for the A-QED functional-consistency tracker.
// Slot states, the pair-count bound and a lowest-index priority picker.
package aqed_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ORIG   = 2'd1,
    PAIRED = 2'd2,
    DONE   = 2'd3
  } slot_state_e;

  // Upper bound on NUM_PAIRS; the picker below works on vectors this wide.
  localparam int MAX_PAIRS = 8;
  localparam int IDX_W     = $clog2(MAX_PAIRS);

  // Returns {found, index} of the lowest set bit of req.
  function automatic logic [IDX_W:0] lowest_set(input logic [MAX_PAIRS-1:0] req);
    lowest_set = '0;
    for (int i = MAX_PAIRS - 1; i >= 0; i--) begin
      if (req[i]) lowest_set = {1'b1, IDX_W'(i)};
    end
  endfunction

endpackage

// File: rtl/aqed_pair_slot.sv
// One orig/dup tracking slot: lifecycle FSM, latched indices and captured
// DUT results for the two marked transactions.
module aqed_pair_slot
  import aqed_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc,
  input  logic              pair,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  in_cnt,
  input  logic              out_valid,
  input  logic [DATA_W-1:0] out_data,
  input  logic [CNT_W-1:0]  out_cnt,
  output logic              is_idle,
  output logic              is_orig,
  output logic [DATA_W-1:0] orig_data,
  output logic              done,
  output logic              match
);

  slot_state_e       state_q, state_d;
  logic [CNT_W-1:0]  orig_idx_q, dup_idx_q;
  logic [DATA_W-1:0] orig_data_q, orig_res_q, dup_res_q;
  logic              orig_got_q, dup_got_q;
  logic              orig_live, dup_live, cap_orig, cap_dup;
  logic [CNT_W-1:0]  orig_idx_eff, dup_idx_eff;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    orig_live    = 1'b0;
    dup_live     = 1'b0;
    orig_idx_eff = orig_idx_q;
    dup_idx_eff  = dup_idx_q;
    cap_orig     = 1'b0;
    cap_dup      = 1'b0;

    case (state_q)
      IDLE:    if (alloc) state_d = ORIG;
      ORIG:    if (pair) state_d = PAIRED;
      PAIRED:  if (orig_got_q && dup_got_q) state_d = DONE;
      default: state_d = state_q;
    endcase

    // A transaction marked in the cycle its own output appears is captured
    // immediately, comparing against the index being latched this cycle.
    orig_live    = (state_q == ORIG) || (state_q == PAIRED) || (state_q == IDLE && alloc);
    orig_idx_eff = (state_q == IDLE) ? in_cnt : orig_idx_q;
    cap_orig     = out_valid && orig_live && !orig_got_q && (out_cnt == orig_idx_eff);

    dup_live     = (state_q == PAIRED) || (state_q == ORIG && pair);
    dup_idx_eff  = (state_q == ORIG) ? in_cnt : dup_idx_q;
    cap_dup      = out_valid && dup_live && !dup_got_q && (out_cnt == dup_idx_eff);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
      state_q     <= IDLE;
      orig_idx_q  <= '0;
      dup_idx_q   <= '0;
      orig_data_q <= '0;
      orig_res_q  <= '0;
      dup_res_q   <= '0;
      orig_got_q  <= 1'b0;
      dup_got_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && alloc) begin
        orig_data_q <= in_data;
        orig_idx_q  <= in_cnt;
      end
      if (state_q == ORIG && pair) begin
        dup_idx_q <= in_cnt;
      end
      if (cap_orig) begin
        orig_res_q <= out_data;
        orig_got_q <= 1'b1;
      end
      if (cap_dup) begin
        dup_res_q <= out_data;
        dup_got_q <= 1'b1;
      end
    end
  end

  assign is_idle   = (state_q == IDLE);
  assign is_orig   = (state_q == ORIG);
  assign orig_data = orig_data_q;
  assign done      = (state_q == DONE);
  assign match     = done && (orig_res_q == dup_res_q);

endmodule

// File: rtl/aqed_fc_multi_tracker.sv
// A-QED functional-consistency tracker: forwards the input stream to the DUT,
// tracks up to NUM_PAIRS orig/dup pairs and reports whether their outputs agree.
module aqed_fc_multi_tracker
  import aqed_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 8,
  parameter int NUM_PAIRS = 2   // 1..MAX_PAIRS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mark_orig,
  input  logic                 mark_dup,
  output logic [DATA_W-1:0]    acc_in_data,
  output logic                 acc_in_valid,
  input  logic                 acc_in_ready,
  input  logic [DATA_W-1:0]    acc_out_data,
  input  logic                 acc_out_valid,
  output logic [NUM_PAIRS-1:0] slot_done,
  output logic [NUM_PAIRS-1:0] slot_match,
  output logic                 qed_done,
  output logic                 qed_check
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                 in_acc, mark_ok, alloc_en, pair_en;
  logic [CNT_W-1:0]     in_cnt, out_cnt;
  logic [NUM_PAIRS-1:0] idle_vec, orig_vec, cand_vec, alloc_vec, pair_vec;
  logic [DATA_W-1:0]    slot_orig_data [NUM_PAIRS];
  logic [IDX_W:0]       alloc_pick, pair_pick;

  assign acc_in_data  = in_data;
  assign acc_in_valid = in_valid;
  assign in_ready     = acc_in_ready;
  assign in_acc       = in_valid && acc_in_ready;

  // Once in_cnt saturates its index no longer identifies one transaction.
  assign mark_ok  = in_acc && (in_cnt != CNT_MAX);
  assign alloc_en = mark_ok && mark_orig;
  assign pair_en  = mark_ok && mark_dup && !mark_orig;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (in_acc && in_cnt != CNT_MAX) in_cnt <= in_cnt + CNT_W'(1);
      if (acc_out_valid && out_cnt != CNT_MAX) out_cnt <= out_cnt + CNT_W'(1);
    end
  end

  assign alloc_pick = lowest_set(MAX_PAIRS'(idle_vec));
  assign pair_pick  = lowest_set(MAX_PAIRS'(cand_vec));
  assign alloc_vec  = (alloc_en && alloc_pick[IDX_W]) ?
                      (NUM_PAIRS'(1) << alloc_pick[IDX_W-1:0]) : '0;
  assign pair_vec   = (pair_en && pair_pick[IDX_W]) ?
                      (NUM_PAIRS'(1) << pair_pick[IDX_W-1:0]) : '0;

  for (genvar k = 0; k < NUM_PAIRS; k++) begin : g_slot
    assign cand_vec[k] = orig_vec[k] && (slot_orig_data[k] == in_data);

    aqed_pair_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .alloc     (alloc_vec[k]),
      .pair      (pair_vec[k]),
      .in_data   (in_data),
      .in_cnt    (in_cnt),
      .out_valid (acc_out_valid),
      .out_data  (acc_out_data),
      .out_cnt   (out_cnt),
      .is_idle   (idle_vec[k]),
      .is_orig   (orig_vec[k]),
      .orig_data (slot_orig_data[k]),
      .done      (slot_done[k]),
      .match     (slot_match[k])
    );
  end

  // A slot that is not done cannot veto the check.
  assign qed_done  = |slot_done;
  assign qed_check = &(slot_match | ~slot_done);

endmodule

// File: tb/tb_aqed_fc_multi_tracker.sv
// Scenario bench for aqed_fc_multi_tracker: the bench plays the accelerator,
// expected status words are queued with the stimulus and popped at check points.
module tb_aqed_fc_multi_tracker;

  localparam int DATA_W    = 16;
  localparam int CNT_W     = 8;
  localparam int NUM_PAIRS = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [DATA_W-1:0]    in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 mark_orig;
  logic                 mark_dup;
  logic [DATA_W-1:0]    acc_in_data;
  logic                 acc_in_valid;
  logic                 acc_in_ready;
  logic [DATA_W-1:0]    acc_out_data;
  logic                 acc_out_valid;
  logic [NUM_PAIRS-1:0] slot_done;
  logic [NUM_PAIRS-1:0] slot_match;
  logic                 qed_done;
  logic                 qed_check;

  always #5 clk = ~clk;

  aqed_fc_multi_tracker #(
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W),
    .NUM_PAIRS (NUM_PAIRS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .mark_orig     (mark_orig),
    .mark_dup      (mark_dup),
    .acc_in_data   (acc_in_data),
    .acc_in_valid  (acc_in_valid),
    .acc_in_ready  (acc_in_ready),
    .acc_out_data  (acc_out_data),
    .acc_out_valid (acc_out_valid),
    .slot_done     (slot_done),
    .slot_match    (slot_match),
    .qed_done      (qed_done),
    .qed_check     (qed_check)
  );

  typedef struct packed {
    logic [NUM_PAIRS-1:0] done;
    logic [NUM_PAIRS-1:0] match;
    logic                 qd;
    logic                 qc;
  } status_t;

  localparam status_t ST_RESET = '{done: 2'b00, match: 2'b00, qd: 1'b0, qc: 1'b1};

  status_t exp_q[$];
  status_t obs, exp_s;
  int checks   = 0;
  int failures = 0;

  function automatic status_t dut_status();
    status_t s;
    s = {slot_done, slot_match, qed_done, qed_check};
    return s;
  endfunction

  task automatic step(input logic iv, input logic [DATA_W-1:0] id, input logic mo,
                      input logic md, input logic ar, input logic ov,
                      input logic [DATA_W-1:0] od);
    in_valid      = iv;
    in_data       = id;
    mark_orig     = mo;
    mark_dup      = md;
    acc_in_ready  = ar;
    acc_out_valid = ov;
    acc_out_data  = od;
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic [DATA_W-1:0] d, input logic mo, input logic md);
    step(1'b1, d, mo, md, 1'b1, 1'b0, '0);
  endtask

  task automatic out(input logic [DATA_W-1:0] d);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, d);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    in_valid      = 1'b0;
    in_data       = '0;
    mark_orig     = 1'b0;
    mark_dup      = 1'b0;
    acc_in_ready  = 1'b1;
    acc_out_valid = 1'b0;
    acc_out_data  = '0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0; in_data = '0; mark_orig = 1'b0; mark_dup = 1'b0;
    acc_in_ready = 1'b0; acc_out_valid = 1'b0; acc_out_data = '0;
    #3;
    exp_q.push_back(ST_RESET);
    obs = dut_status(); exp_s = exp_q.pop_front(); checks++;
    if (obs !== exp_s) begin failures++; $display("FAIL reset_status: got %b expected %b", obs, exp_s); end
    do_reset();
    exp_q.push_back(ST_RESET);
    obs = dut_status(); exp_s = exp_q.pop_front(); checks++;
    if (obs !== exp_s) begin failures++; $display("FAIL reset_release_status: got %b expected %b", obs, exp_s); end
    in_valid = 1'b1; in_data = 16'hBEEF; acc_in_ready = 1'b1;
    #1;
    checks++;
    if (acc_in_data !== 16'hBEEF) begin failures++; $display("FAIL fwd_data: got %h expected beef", acc_in_data); end
    checks++;
    if (acc_in_valid !== 1'b1) begin failures++; $display("FAIL fwd_valid: got %b expected 1", acc_in_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL fwd_ready: got %b expected 1", in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic run_single(input logic [DATA_W-1:0] third, input status_t final_st,
                            input string tag);
    do_reset();
    acc(16'h0005, 1'b1, 1'b0);
    acc(16'h0007, 1'b0, 1'b0);
    acc(16'h0005, 1'b0, 1'b1);
    out(16'h00A0);
    out(16'h00B0);
    out(third);
    exp_q.push_back(ST_RESET);
    obs = dut_status(); exp_s = exp_q.pop_front(); checks++;
    if (obs !== exp_s) begin failures++; $display("FAIL %s_capture_edge: got %b expected %b", tag, obs, exp_s); end
    idle();
    exp_q.push_back(final_st);
    obs = dut_status(); exp_s = exp_q.pop_front(); checks++;
    if (obs !== exp_s) begin failures++; $display("FAIL %s_done: got %b expected %b", tag, obs, exp_s); end
  endtask

  task automatic test_single_pair();
    run_single(16'h00A0, '{done: 2'b01, match: 2'b01, qd: 1'b1, qc: 1'b1}, "single");
  endtask

  task automatic test_mismatch();
    run_single(16'h00A1, '{done: 2'b01, match: 2'b00, qd: 1'b1, qc: 1'b0}, "mismatch");
  endtask

  task automatic test_two_pairs();
    do_reset();
    acc(16'h0011, 1'b1, 1'b0);
    acc(16'h0022, 1'b1, 1'b0);
    acc(16'h0022, 1'b0, 1'b1);
    acc(16'h0011, 1'b0, 1'b1);
    exp_q.push_back('{done: 2'b11, match: 2'b11, qd: 1'b1, qc: 1'b1});
    out(16'h0100);
    out(16'h0200);
    out(16'h0200);
    out(16'h0100);
    idle();
    obs = dut_status(); exp_s = exp_q.pop_front(); checks++;
    if (obs !== exp_s) begin failures++; $display("FAIL two_pairs_done: got %b expected %b", obs, exp_s); end
  endtask

  task automatic test_unmatched_dup();
    do_reset();
    acc(16'h0003, 1'b1, 1'b0);
    acc(16'h0004, 1'b0, 1'b1);
    exp_q.push_back(ST_RESET);
    out(16'h0030);
    out(16'h0040);
    idle();
    obs = dut_status(); exp_s = exp_q.pop_front(); checks++;
    if (obs !== exp_s) begin failures++; $display("FAIL unmatched_ignored: got %b expected %b", obs, exp_s); end
    acc(16'h0003, 1'b0, 1'b1);
    exp_q.push_back('{done: 2'b01, match: 2'b01, qd: 1'b1, qc: 1'b1});
    out(16'h0030);
    idle();
    obs = dut_status(); exp_s = exp_q.pop_front(); checks++;
    if (obs !== exp_s) begin failures++; $display("FAIL unmatched_late_pair: got %b expected %b", obs, exp_s); end
  endtask

  task automatic test_backpressure_simul();
    do_reset();
    in_valid = 1'b1; in_data = 16'h0040; mark_orig = 1'b1; mark_dup = 1'b0;
    acc_in_ready = 1'b0; acc_out_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    @(posedge clk);
    #1;
    // Each cycle below accepts an input and also returns that same transaction's output.
    step(1'b1, 16'h0040, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0055);
    step(1'b1, 16'h0040, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0066);
    step(1'b1, 16'h0040, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0055);
    exp_q.push_back(ST_RESET);
    obs = dut_status(); exp_s = exp_q.pop_front(); checks++;
    if (obs !== exp_s) begin failures++; $display("FAIL simul_capture_edge: got %b expected %b", obs, exp_s); end
    idle();
    exp_q.push_back('{done: 2'b01, match: 2'b01, qd: 1'b1, qc: 1'b1});
    obs = dut_status(); exp_s = exp_q.pop_front(); checks++;
    if (obs !== exp_s) begin failures++; $display("FAIL simul_done: got %b expected %b", obs, exp_s); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    acc(16'h0005, 1'b1, 1'b0);
    acc(16'h0005, 1'b0, 1'b1);
    out(16'h0077);
    #2;
    reset = 1'b0;
    #1;
    exp_q.push_back(ST_RESET);
    obs = dut_status(); exp_s = exp_q.pop_front(); checks++;
    if (obs !== exp_s) begin failures++; $display("FAIL midop_reset_paired: got %b expected %b", obs, exp_s); end
    reset = 1'b1;
    acc(16'h0008, 1'b1, 1'b0);
    acc(16'h0008, 1'b0, 1'b1);
    out(16'h0012);
    out(16'h0012);
    idle();
    exp_q.push_back('{done: 2'b01, match: 2'b01, qd: 1'b1, qc: 1'b1});
    obs = dut_status(); exp_s = exp_q.pop_front(); checks++;
    if (obs !== exp_s) begin failures++; $display("FAIL post_reset_pair: got %b expected %b", obs, exp_s); end
    #2;
    reset = 1'b0;
    #1;
    exp_q.push_back(ST_RESET);
    obs = dut_status(); exp_s = exp_q.pop_front(); checks++;
    if (obs !== exp_s) begin failures++; $display("FAIL midop_reset_done: got %b expected %b", obs, exp_s); end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_mismatch();
    test_two_pairs();
    test_unmatched_dup();
    test_backpressure_simul();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
